// File: rtl/top.sv
// Adaptive tone curve: per-frame mean luma sets the curve strength k, and each
// channel is mapped through f(x) = x + k*x*(255-x)/65536 in a 3-stage pipeline.
module top #(
    parameter int DARK_TH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] i_rgb,
    input  logic        i_de,
    input  logic        i_vs,
    input  logic        i_hs,
    output logic [23:0] o_rgb,
    output logic        o_de
);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // ---------------- luma and frame statistics ----------------
    logic [15:0] y_full;
    logic [7:0]  y;
    logic [31:0] sum_y;
    logic [23:0] cnt;
    logic [32:0] sum_next;
    logic [24:0] cnt_next;
    logic        vs_d;
    logic        frame_edge;

    assign y_full = 16'd77  * {8'd0, i_rgb[23:16]}
                  + 16'd150 * {8'd0, i_rgb[15:8]}
                  + 16'd29  * {8'd0, i_rgb[7:0]};
    assign y          = y_full[15:8];
    assign sum_next   = {1'b0, sum_y} + {25'd0, y};
    assign cnt_next   = {1'b0, cnt} + 25'd1;
    assign frame_edge = i_vs && !vs_d;

    // The pixel arriving in the frame-edge cycle seeds the new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_d  <= 1'b0;
            sum_y <= '0;
            cnt   <= '0;
        end else begin
            vs_d <= i_vs;
            if (frame_edge) begin
                sum_y <= i_de ? {24'd0, y} : 32'd0;
                cnt   <= i_de ? 24'd1 : 24'd0;
            end else if (i_de) begin
                sum_y <= sum_next[32] ? '1 : sum_next[31:0];
                cnt   <= cnt_next[24] ? '1 : cnt_next[23:0];
            end
        end
    end

    // ---------------- serial restoring divider ----------------
    div_state_t  div_state;
    div_state_t  div_next;
    logic        div_start;
    logic        div_load;
    logic        div_step;
    logic        div_finish;
    logic [31:0] dvd;
    logic [31:0] quo;
    logic [23:0] dvs;
    logic [23:0] rem;
    logic [4:0]  bit_cnt;
    logic [24:0] rem_sh;
    logic [24:0] rem_diff;
    logic        rem_ge;
    logic [7:0]  mean_new;
    logic [7:0]  mean_reg;
    logic [7:0]  k;

    // A frame edge while busy is ignored here; the running divide keeps its snapshot.
    assign div_start = frame_edge && (div_state == DIV_IDLE) && (cnt != 24'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) div_state <= DIV_IDLE;
        else        div_state <= div_next;
    end

    always_comb begin
        div_next = div_state;
        case (div_state)
            DIV_IDLE: if (div_start) div_next = DIV_RUN;
            DIV_RUN:  if (bit_cnt == 5'd31) div_next = DIV_DONE;
            DIV_DONE: div_next = DIV_IDLE;
            default:  div_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        div_load   = 1'b0;
        div_step   = 1'b0;
        div_finish = 1'b0;
        case (div_state)
            DIV_IDLE: div_load   = div_start;
            DIV_RUN:  div_step   = 1'b1;
            DIV_DONE: div_finish = 1'b1;
            default:  ;
        endcase
    end

    assign rem_sh   = {rem, dvd[31]};
    assign rem_diff = rem_sh - {1'b0, dvs};
    assign rem_ge   = rem_sh >= {1'b0, dvs};
    assign mean_new = (quo > 32'd255) ? 8'd255 : quo[7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            bit_cnt  <= '0;
            mean_reg <= 8'd128;
            k        <= 8'd127;
        end else begin
            if (div_load) begin
                dvd     <= sum_y;
                dvs     <= cnt;
                rem     <= '0;
                quo     <= '0;
                bit_cnt <= '0;
            end else if (div_step) begin
                rem     <= rem_ge ? rem_diff[23:0] : rem_sh[23:0];
                quo     <= {quo[30:0], rem_ge};
                dvd     <= {dvd[30:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (div_finish) begin
                mean_reg <= mean_new;
                k        <= (int'({24'd0, mean_new}) < DARK_TH) ? 8'd255 : 8'd255 - mean_new;
            end
        end
    end

    // ---------------- curve pipeline ----------------
    logic [7:0]  chan_in [3];
    logic [7:0]  x1      [3];
    logic [15:0] p1      [3];
    logic [7:0]  x2      [3];
    logic [7:0]  p2      [3];
    logic [23:0] prod    [3];
    logic [8:0]  sum9    [3];
    logic [7:0]  k1;
    logic        v1;
    logic        v2;
    logic [23:0] rgb_next;

    always_comb begin
        rgb_next = '0;
        for (int c = 0; c < 3; c++) begin
            chan_in[c] = i_rgb[c*8 +: 8];
            prod[c]    = {16'd0, k1} * {8'd0, p1[c]};
            sum9[c]    = {1'b0, x2[c]} + {1'b0, p2[c]};
            rgb_next[c*8 +: 8] = sum9[c][8] ? 8'hFF : sum9[c][7:0];
        end
    end

    // Each pixel carries the k it saw on entry, so a k update never splits a pixel.
    always_ff @(posedge clk) begin
        k1 <= k;
        for (int c = 0; c < 3; c++) begin
            x1[c] <= chan_in[c];
            p1[c] <= {8'd0, chan_in[c]} * {8'd0, 8'd255 - chan_in[c]};
            x2[c] <= x1[c];
            p2[c] <= prod[c][23:16];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            o_de  <= 1'b0;
            o_rgb <= '0;
        end else begin
            v1   <= i_de;
            v2   <= v1;
            o_de <= v2;
            if (v2) o_rgb <= rgb_next;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{i_hs, y_full[7:0], rem_diff[24], prod[0][15:0],
                         prod[1][15:0], prod[2][15:0], mean_reg};

endmodule

// File: tb/tb_top.sv
// Directed bench for the adaptive tone curve: latency, endpoints, frame
// statistics driving k, edge-cycle pixels, busy-divider edges and reset.
module tb_top;

    logic        clk;
    logic        rst_n;
    logic [23:0] i_rgb;
    logic        i_de;
    logic        i_vs;
    logic        i_hs;
    logic [23:0] o_rgb;
    logic        o_de;

    int pass_cnt  = 0;
    int check_cnt = 0;

    top #(.DARK_TH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rgb (i_rgb),
        .i_de  (i_de),
        .i_vs  (i_vs),
        .i_hs  (i_hs),
        .o_rgb (o_rgb),
        .o_de  (o_de)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_de  = 1'b0;
        i_vs  = 1'b0;
        i_rgb = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // Drive one pixel, return at the negedge after which its result is visible.
    task automatic drive_pixel_wait(input logic [23:0] p);
        @(negedge clk);
        i_rgb = p;
        i_de  = 1'b1;
        @(negedge clk);
        i_de  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [23:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_rgb = p;
            i_de  = 1'b1;
        end
        @(negedge clk);
        i_de = 1'b0;
    endtask

    task automatic frame_edge(input int idle);
        @(negedge clk);
        i_vs = 1'b1;
        @(negedge clk);
        i_vs = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_de  = 1'b1;
        i_rgb = 24'h123456;
        @(negedge clk);
        check_cnt++;
        if (o_de !== 1'b0) $display("FAIL reset_o_de: got %b want 0", o_de);
        else pass_cnt++;
        check_cnt++;
        if (o_rgb !== 24'h0) $display("FAIL reset_o_rgb: got %h want 000000", o_rgb);
        else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_mid_gray();
        apply_reset();
        @(negedge clk);
        i_rgb = 24'h808080;
        i_de  = 1'b1;
        @(negedge clk);
        i_de = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (o_de !== 1'b0) $display("FAIL gray_early_o_de: got %b want 0", o_de);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (o_de !== 1'b1 || o_rgb !== 24'h9F9F9F)
            $display("FAIL gray_k127: got de=%b rgb=%h want de=1 rgb=9f9f9f", o_de, o_rgb);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (o_de !== 1'b0 || o_rgb !== 24'h9F9F9F)
            $display("FAIL gray_hold: got de=%b rgb=%h want de=0 rgb=9f9f9f", o_de, o_rgb);
        else pass_cnt++;
    endtask

    task automatic test_primaries();
        logic [23:0] pix [3];
        pix[0] = 24'hFF0000;
        pix[1] = 24'h00FF00;
        pix[2] = 24'h0000FF;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                check_cnt++;
                if (o_de !== 1'b1 || o_rgb !== pix[i-3])
                    $display("FAIL primary_%0d: got de=%b rgb=%h want de=1 rgb=%h", i-3, o_de, o_rgb, pix[i-3]);
                else pass_cnt++;
            end
            i_de  = (i < 3);
            i_rgb = (i < 3) ? pix[i] : 24'h0;
        end
    endtask

    task automatic test_dark_frame();
        apply_reset();
        send_frame(24'h202020, 64);
        frame_edge(40);
        drive_pixel_wait(24'h202020);
        check_cnt++;
        if (o_de !== 1'b1 || o_rgb !== 24'h3B3B3B)
            $display("FAIL dark_k255: got de=%b rgb=%h want de=1 rgb=3b3b3b", o_de, o_rgb);
        else pass_cnt++;
    endtask

    task automatic test_bright_frame();
        apply_reset();
        send_frame(24'hC0C0C0, 64);
        frame_edge(40);
        drive_pixel_wait(24'h808080);
        check_cnt++;
        if (o_rgb !== 24'h8F8F8F)
            $display("FAIL bright_k63: got %h want 8f8f8f", o_rgb);
        else pass_cnt++;
        drive_pixel_wait(24'h00FF80);
        check_cnt++;
        if (o_rgb !== 24'h00FF8F)
            $display("FAIL bright_endpoints: got %h want 00ff8f", o_rgb);
        else pass_cnt++;
    endtask

    task automatic test_empty_frame();
        apply_reset();
        send_frame(24'h202020, 64);
        frame_edge(40);
        frame_edge(40);
        drive_pixel_wait(24'h202020);
        check_cnt++;
        if (o_rgb !== 24'h3B3B3B)
            $display("FAIL empty_keeps_k: got %h want 3b3b3b", o_rgb);
        else pass_cnt++;
    endtask

    task automatic test_busy_edge();
        apply_reset();
        send_frame(24'h202020, 64);
        frame_edge(0);
        send_frame(24'hC0C0C0, 5);
        frame_edge(40);
        drive_pixel_wait(24'h202020);
        check_cnt++;
        if (o_rgb !== 24'h3B3B3B)
            $display("FAIL busy_edge_discard: got %h want 3b3b3b", o_rgb);
        else pass_cnt++;
    endtask

    // Frame = {FFFFFF in edge cycle, 404040}: mean 159, k = 96 -> 0x80 maps to 0x97.
    task automatic test_edge_pixel();
        apply_reset();
        @(negedge clk);
        i_vs  = 1'b1;
        i_de  = 1'b1;
        i_rgb = 24'hFFFFFF;
        @(negedge clk);
        i_vs  = 1'b0;
        i_rgb = 24'h404040;
        @(negedge clk);
        i_de = 1'b0;
        frame_edge(40);
        drive_pixel_wait(24'h808080);
        check_cnt++;
        if (o_rgb !== 24'h979797)
            $display("FAIL edge_pixel_counted: got %h want 979797", o_rgb);
        else pass_cnt++;
    endtask

    // Continuous stream across a frame edge; all pixels still see k = 127.
    task automatic test_back_to_back();
        logic [23:0] exp_q[$];
        logic [23:0] pix;
        logic [23:0] want;
        apply_reset();
        exp_q.push_back(24'h000000); exp_q.push_back(24'hFF0000);
        exp_q.push_back(24'h9F9F9F); exp_q.push_back(24'h00FF00);
        exp_q.push_back(24'h9F00FF); exp_q.push_back(24'h9F9F9F);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                want = exp_q.pop_front();
                check_cnt++;
                if (o_de !== 1'b1 || o_rgb !== want)
                    $display("FAIL stream_%0d: got de=%b rgb=%h want de=1 rgb=%h", i-3, o_de, o_rgb, want);
                else pass_cnt++;
            end
            case (i)
                0: pix = 24'h000000;
                1: pix = 24'hFF0000;
                2: pix = 24'h808080;
                3: pix = 24'h00FF00;
                4: pix = 24'h8000FF;
                default: pix = 24'h808080;
            endcase
            i_de  = (i < 6);
            i_vs  = (i == 2 || i == 3);
            i_rgb = pix;
        end
        @(negedge clk);
        check_cnt++;
        if (o_de !== 1'b0) $display("FAIL stream_tail_o_de: got %b want 0", o_de);
        else pass_cnt++;
        i_vs = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        send_frame(24'h202020, 64);
        frame_edge(40);
        send_frame(24'h101010, 10);
        @(negedge clk);
        i_rgb = 24'h202020;
        i_de  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        i_de  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (o_de !== 1'b0) $display("FAIL midreset_o_de: got %b want 0", o_de);
        else pass_cnt++;
        drive_pixel_wait(24'h808080);
        check_cnt++;
        if (o_de !== 1'b1 || o_rgb !== 24'h9F9F9F)
            $display("FAIL midreset_k127: got de=%b rgb=%h want de=1 rgb=9f9f9f", o_de, o_rgb);
        else pass_cnt++;
        frame_edge(40);
        drive_pixel_wait(24'h808080);
        check_cnt++;
        if (o_rgb !== 24'h9F9F9F)
            $display("FAIL midreset_stats_cleared: got %h want 9f9f9f", o_rgb);
        else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        i_rgb = '0;
        i_de  = 1'b0;
        i_vs  = 1'b0;
        i_hs  = 1'b0;
        test_reset();
        test_mid_gray();
        test_primaries();
        test_dark_frame();
        test_bright_frame();
        test_empty_frame();
        test_busy_edge();
        test_edge_pixel();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
